// File: rtl/target_spawner.sv
// target_spawner: random-delay target spawner with shot hit-testing and hit/miss tallies
module target_spawner #(
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter int          TAR_SIZE    = 8,
  parameter logic [25:0] DELAY_BASE  = 26'd25000000,
  parameter int          DELAY_SHIFT = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       titleoff,
  input  logic       over,
  input  logic       clear,
  input  logic       tar,
  input  logic       shot,
  input  logic [7:0] aim_x,
  input  logic [6:0] aim_y,
  output logic       spawn,
  output logic       kill,
  output logic [7:0] tar_x,
  output logic [6:0] tar_y,
  output logic [7:0] hits,
  output logic [7:0] misses
);
  typedef enum logic [2:0] {IDLE, DELAY, SPAWN, ARMED, KILL, HOLD} state_t;
  localparam logic [7:0] X_SPAN = 8'(SCREEN_W - TAR_SIZE);
  localparam logic [6:0] Y_SPAN = 7'(SCREEN_H - TAR_SIZE);
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [25:0] cnt, delay_ld;
  logic abort, hit, fire;
  assign abort    = !titleoff || over;
  assign delay_ld = DELAY_BASE + (26'(lfsr[7:0]) << DELAY_SHIFT);
  assign hit      = {1'b0, aim_x} >= {1'b0, tar_x} && {1'b0, aim_x} < {1'b0, tar_x} + 9'(TAR_SIZE)
                 && {1'b0, aim_y} >= {1'b0, tar_y} && {1'b0, aim_y} < {1'b0, tar_y} + 8'(TAR_SIZE);
  assign fire     = state == ARMED && !abort && shot && tar;
  assign spawn    = state == SPAWN;
  assign kill     = state == KILL;
  // next-state selection; abort overrides every state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = clear ? DELAY : IDLE;
      DELAY:   state_nx = cnt == '0 ? SPAWN : DELAY;
      SPAWN:   state_nx = ARMED;
      ARMED:   state_nx = shot && tar && hit ? KILL : ARMED;
      KILL:    state_nx = HOLD;
      HOLD:    state_nx = clear ? DELAY : HOLD;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  // state, LFSR, delay counter, target position and tallies
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      cnt    <= '0;
      tar_x  <= '0;
      tar_y  <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
      cnt   <= state_nx == DELAY && state != DELAY ? delay_ld
             : state == DELAY && cnt != '0 ? cnt - 26'd1 : cnt;
      if (state_nx == SPAWN && state != SPAWN) begin
        tar_x <= lfsr[7:0] >= X_SPAN ? lfsr[7:0] - X_SPAN : lfsr[7:0];
        tar_y <= lfsr[14:8] >= Y_SPAN ? lfsr[14:8] - Y_SPAN : lfsr[14:8];
      end
      if (state == IDLE && !titleoff) begin
        hits   <= '0;
        misses <= '0;
      end else if (fire) begin
        hits   <= hit && hits != 8'hFF ? hits + 8'd1 : hits;
        misses <= !hit && misses != 8'hFF ? misses + 8'd1 : misses;
      end
    end
  end
endmodule
